// File: rtl/op_trans_pkg.sv
// Shared types and helpers for the op_trans stage: arbiter state encoding,
// default word widths and a width-parameterised sign-extension function.
package op_trans_pkg;

  localparam int unsigned OP_IN_W   = 10;
  localparam int unsigned OP_OUT_W  = 14;
  localparam int unsigned EXT_MAX_W = 64;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

  // Replicates bit in_w-1 of word into every higher bit; callers truncate
  // the result to their own output width.
  function automatic logic [EXT_MAX_W-1:0] ext_sign(input logic [EXT_MAX_W-1:0] word,
                                                    input int unsigned          in_w);
    logic [EXT_MAX_W-1:0] r;
    r = word;
    for (int unsigned i = 0; i < EXT_MAX_W; i++) begin
      if (i >= in_w) r[i] = word[in_w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/op_trans_rr_pick.sv
// Combinational find-first-valid search starting at ptr and wrapping
// from NUM_REQ-1 back to 0.
module op_trans_rr_pick #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  valid,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [ID_WIDTH-1:0] grant,
  output logic                any_valid
);

  always_comb begin
    int unsigned idx;
    grant     = '0;
    any_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!any_valid && valid[idx]) begin
        any_valid = 1'b1;
        grant     = ID_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/op_trans_ext_arb.sv
// Round-robin arbiter feeding one shared sign-extension lane with a
// registered output. Optional burst lock enabled by defining S2L_LOCK_EN.
module op_trans_ext_arb
  import op_trans_pkg::*;
#(
  parameter  int unsigned NUM_REQ      = 4,
  parameter  int unsigned INPUT_WIDTH  = OP_IN_W,
  parameter  int unsigned OUTPUT_WIDTH = OP_OUT_W,
  localparam int unsigned ID_WIDTH     = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           out_valid,
  output logic [OUTPUT_WIDTH-1:0]        out_data,
  output logic [ID_WIDTH-1:0]            out_id,
  output logic                           out_last,
  input  logic                           out_ready
);

  logic [ID_WIDTH-1:0]    ptr;
  logic [ID_WIDTH-1:0]    ptr_next;
  logic [ID_WIDTH-1:0]    grant;
  logic [NUM_REQ-1:0]     cand;
  logic                   any_valid;
  logic                   load;
  logic                   xfer;
  logic                   advance;
  logic                   last_bit;
  logic [INPUT_WIDTH-1:0] sel_word;

`ifdef S2L_LOCK_EN
  arb_state_t          state, state_d;
  logic [ID_WIDTH-1:0] lock_id, lock_id_d;

  // While locked only the burst owner is visible to the picker.
  always_comb begin
    cand = req_valid;
    if (state == LOCKED) cand = req_valid & (NUM_REQ'(1) << lock_id);
  end

  always_comb begin
    state_d   = state;
    lock_id_d = lock_id;
    if (xfer) begin
      case (state)
        IDLE: begin
          if (!req_last[grant]) begin
            state_d   = LOCKED;
            lock_id_d = grant;
          end
        end
        LOCKED: begin
          if (req_last[grant]) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lock_id <= '0;
    end else begin
      state   <= state_d;
      lock_id <= lock_id_d;
    end
  end

  assign advance  = req_last[grant];
  assign last_bit = req_last[grant];
`else
  logic unused_last;

  assign cand        = req_valid;
  assign advance     = 1'b1;
  assign last_bit    = 1'b0;
  assign unused_last = ^req_last;
`endif

  op_trans_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_WIDTH(ID_WIDTH)
  ) u_pick (
    .valid    (cand),
    .ptr      (ptr),
    .grant    (grant),
    .any_valid(any_valid)
  );

  assign load      = ~out_valid | out_ready;
  assign xfer      = load & any_valid & ~rst;
  assign req_ready = xfer ? (NUM_REQ'(1) << grant) : '0;
  assign ptr_next  = (grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant + ID_WIDTH'(1);
  assign sel_word  = req_data[grant*INPUT_WIDTH +: INPUT_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (xfer && advance) begin
      ptr <= ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= any_valid;
      if (any_valid) begin
        out_data <= OUTPUT_WIDTH'(ext_sign(EXT_MAX_W'(sel_word), INPUT_WIDTH));
        out_id   <= grant;
        out_last <= last_bit;
      end
    end
  end

endmodule
